// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Holds the clear-engine state encoding and the depth helper.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register pending bits: set on reservation, cleared by writeback, flushed on clear.
// Set has priority over clear so a new producer survives a same-cycle retirement.
module reg_bank_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_addr,
  input  logic                     i_clr_en,
  input  logic [ADDR_W-1:0]        i_clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_pend
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] r_pend;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_flush) begin
      r_pend <= '0;
    end else begin
      if (i_clr_en) r_pend[i_clr_addr] <= 1'b0;
      if (i_set_en) r_pend[i_set_addr] <= 1'b1;
    end
  end

  always_comb begin
    o_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      o_pend[i] = r_pend[i_rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/reg_bank_param.sv
// Register bank with combinational read ports, one write port, bypass, zero register,
// pending scoreboard and a one-entry-per-cycle clear engine run after reset or on request.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_pend,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic                     i_clr_req,
  output logic                     o_busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_clr_wr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_busy;
  logic                w_wr_ok;
  logic                w_rsv_ok;
  logic                w_flush;
  logic [NUM_RD-1:0]   w_hit;
  logic [NUM_RD-1:0]   w_sb_pend;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_wr_ok  = i_wr_en && !w_busy && !(ZERO_REG && (i_wr_addr == '0));
  assign w_rsv_ok = i_rsv_en && !w_busy && !(ZERO_REG && (i_rsv_addr == '0));
  assign w_flush  = (r_state == ST_IDLE) && i_clr_req;
  assign o_busy   = w_busy;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_wr    = 1'b0;
    case (r_state)
      ST_INIT, ST_CLEAR: begin
        w_clr_wr = 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_clr_req) w_state_nxt = ST_CLEAR;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array itself is not reset; the clear engine zeroes it after every reset.
  always_ff @(posedge i_clock) begin
    if (i_reset_n) begin
      if (w_clr_wr)     r_mem[r_cnt]     <= '0;
      else if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  reg_bank_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_flush    (w_flush),
    .i_set_en   (w_rsv_ok),
    .i_set_addr (i_rsv_addr),
    .i_clr_en   (w_wr_ok),
    .i_clr_addr (i_wr_addr),
    .i_rd_addr  (i_rd_addr),
    .o_pend     (w_sb_pend)
  );

  always_comb begin
    o_rd_data = '0;
    o_rd_pend = '0;
    w_hit     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_hit[i] = BYPASS && w_wr_ok && (i_wr_addr == i_rd_addr[i*ADDR_W +: ADDR_W]);
      if (!w_busy) begin
        if (ZERO_REG && (i_rd_addr[i*ADDR_W +: ADDR_W] == '0))
          o_rd_data[i*DATA_W +: DATA_W] = '0;
        else if (w_hit[i])
          o_rd_data[i*DATA_W +: DATA_W] = i_wr_data;
        else
          o_rd_data[i*DATA_W +: DATA_W] = r_mem[i_rd_addr[i*ADDR_W +: ADDR_W]];
        o_rd_pend[i] = w_sb_pend[i] & ~w_hit[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed test of reg_bank_param: init/clear timing, bypass, zero register,
// scoreboard set/clear priority and reset during a clear.
module tb_reg_bank_param;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        clr_req;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  reg_bank_param dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_pend  (rd_pend),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_clr_req  (clr_req),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
  endtask

  // Counts clock edges until busy drops, bounded.
  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;

    // 1: reset, init length, all zero
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("busy_after_reset", {31'd0, busy}, 32'd1);
    set_rd(5'd3, 5'd4);
    #1;
    check("rd_zero_while_busy", rd_data[31:0], 32'd0);
    check("pend_zero_while_busy", {30'd0, rd_pend}, 32'd0);
    busy_len(n);
    check("init_len", n, 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      check($sformatf("init_r%0d_p0", a), rd_data[31:0], 32'd0);
      check($sformatf("init_r%0d_p1", 31 - a), rd_data[63:32], 32'd0);
    end

    // 2: bypass then stored value
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd5);
    #1;
    check("bypass_p0", rd_data[31:0], 32'hDEADBEEF);
    check("bypass_p1", rd_data[63:32], 32'hDEADBEEF);
    tick();
    idle_inputs();
    #1;
    check("r5_stored", rd_data[31:0], 32'hDEADBEEF);

    // 3: zero register is never written or reserved
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    check("r0_no_bypass", rd_data[31:0], 32'd0);
    tick();
    idle_inputs();
    #1;
    check("r0_after_write", rd_data[63:32], 32'd0);
    check("r0_not_pend", {30'd0, rd_pend}, 32'd0);

    // 4: reserve then write retires the reservation
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle_inputs();
    set_rd(5'd7, 5'd7);
    #1;
    check("r7_pend", {30'd0, rd_pend}, 32'd3);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    #1;
    check("r7_pend_bypassed", {30'd0, rd_pend}, 32'd0);
    check("r7_bypass_data", rd_data[31:0], 32'h11);
    tick();
    idle_inputs();
    #1;
    check("r7_pend_cleared", {30'd0, rd_pend}, 32'd0);
    check("r7_data", rd_data[63:32], 32'h11);

    // 5: reserve and write same register same cycle -> stays pending
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
    set_rd(5'd9, 5'd7);
    #1;
    check("r9_same_cycle_pend", {31'd0, rd_pend[0]}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("r9_data", rd_data[31:0], 32'h22);
    check("r9_pend_set_wins", {30'd0, rd_pend}, 32'd1);

    // 6: fill, clear with dropped traffic, then reset mid-clear
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h01010101 * a;
      tick();
    end
    idle_inputs();
    set_rd(5'd17, 5'd31);
    #1;
    check("fill_r17", rd_data[31:0], 32'h11111111);
    check("fill_r31", rd_data[63:32], 32'h1F1F1F1F);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1;
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_rd_zero", rd_data[31:0], 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 5) clr_req = 1'b0;
      tick();
      n++;
    end
    idle_inputs();
    check("clr_len", n, 32'd32);
    #1;
    for (int a = 1; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      #1;
      check($sformatf("clr_r%0d", a), rd_data[31:0], 32'd0);
      check($sformatf("clr_pend_r%0d", a), {30'd0, rd_pend}, 32'd0);
    end

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    check("busy_mid_clear", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("busy_after_mid_reset", {31'd0, busy}, 32'd1);
    busy_len(n);
    check("reinit_len", n, 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
